// File: rtl/rm_index_gen_pkg.sv
// -----------------------------------------------------------------------------
// rm_index_gen_pkg
// Shared types and default widths for the Random Modulo set-index generator.
//   rm_seed_t         : placement seed (two PRNG words)
//   rm_set_idx_t      : L1 set index
//   rm_reseed_state_t : reseed handshake FSM states
//   rm_num_chunks()   : number of set-index-wide chunks needed to cover a seed
// -----------------------------------------------------------------------------
package rm_index_gen_pkg;

    localparam int RM_SEED_WIDTH    = 32;
    localparam int RM_RAND_WIDTH    = 16;
    localparam int RM_SET_IDX_WIDTH = 6;
    localparam int RM_OFFSET_WIDTH  = 6;
    localparam int RM_ADDR_WIDTH    = 32;

    typedef logic [RM_SEED_WIDTH-1:0]    rm_seed_t;
    typedef logic [RM_SET_IDX_WIDTH-1:0] rm_set_idx_t;

    typedef enum logic [1:0] {
        RM_IDLE,
        RM_CAP_LO,
        RM_CAP_HI,
        RM_COMMIT
    } rm_reseed_state_t;

    // Ceiling division: the last chunk of the seed may be only partially filled.
    function automatic int rm_num_chunks(input int seed_w, input int idx_w);
        return (seed_w + idx_w - 1) / idx_w;
    endfunction

endpackage

// File: rtl/rm_index_gen_hash.sv
// -----------------------------------------------------------------------------
// rm_index_hash
// Purely combinational randomized set-index mapping. Also usable by the
// tag-compare path to rebuild the set a writeback address maps to.
//   tag_i     : address tag bits
//   idx_i     : conventional (modulo) set index bits
//   seed_i    : current placement seed
//   set_idx_o : randomized set index
// Configuration macro RANDOM_MODULO_EN:
//   defined   -> set_idx = rotate_left(idx, k mod W) ^ k, where k folds (tag ^ seed)
//   undefined -> set_idx = idx (plain modulo placement, seed ignored)
// -----------------------------------------------------------------------------
module rm_index_hash
    import rm_index_gen_pkg::*;
#(
    parameter int SEED_WIDTH    = RM_SEED_WIDTH,
    parameter int SET_IDX_WIDTH = RM_SET_IDX_WIDTH,
    parameter int TAG_WIDTH     = RM_ADDR_WIDTH - RM_SET_IDX_WIDTH - RM_OFFSET_WIDTH
) (
    input  logic [TAG_WIDTH-1:0]     tag_i,
    input  logic [SET_IDX_WIDTH-1:0] idx_i,
    input  logic [SEED_WIDTH-1:0]    seed_i,
    output logic [SET_IDX_WIDTH-1:0] set_idx_o
);

`ifdef RANDOM_MODULO_EN
    localparam int NUM_CHUNKS = rm_num_chunks(SEED_WIDTH, SET_IDX_WIDTH);
    localparam int PAD_WIDTH  = NUM_CHUNKS * SET_IDX_WIDTH;
    localparam logic [SET_IDX_WIDTH-1:0] IDX_MOD = SET_IDX_WIDTH'(SET_IDX_WIDTH);

    logic [PAD_WIDTH-1:0]       x_pad;
    logic [SET_IDX_WIDTH-1:0]   k;
    logic [SET_IDX_WIDTH-1:0]   rot;
    logic [2*SET_IDX_WIDTH-1:0] rot_wide;

    // x_pad carries the zero-padded top chunk; k is the XOR-fold of all chunks.
    // Rotating via a doubled copy lets the upper half hold rotate_left(idx, rot).
    always_comb begin
        x_pad                 = '0;
        x_pad[SEED_WIDTH-1:0] = SEED_WIDTH'(tag_i) ^ seed_i;
        k                     = '0;
        for (int c = 0; c < NUM_CHUNKS; c++) begin
            k = k ^ x_pad[c*SET_IDX_WIDTH +: SET_IDX_WIDTH];
        end
        rot       = k % IDX_MOD;
        rot_wide  = {idx_i, idx_i} << rot;
        set_idx_o = rot_wide[2*SET_IDX_WIDTH-1 -: SET_IDX_WIDTH] ^ k;
    end
`else
    // Plain modulo placement; tag and seed are intentionally ignored.
    logic unused_hash_inputs;

    assign set_idx_o          = idx_i;
    assign unused_hash_inputs = ^{tag_i, seed_i};
`endif

endmodule

// File: rtl/rm_index_gen.sv
// -----------------------------------------------------------------------------
// rm_index_gen
// Random Modulo set-index generator for the L1 caches. Builds a placement seed
// from two PRNG words on request and maps each lookup address to a set index.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   rand_i              : PRNG word, new value every cycle
//   reseed_req          : single-cycle request to draw a new seed
//   reseed_busy         : high while the reseed FSM is not idle
//   reseed_done         : one-cycle pulse in the cycle the new seed commits
//   lookup_valid_i/addr : lookup request (byte address)
//   lookup_valid_o      : registered lookup valid
//   lookup_set_idx_o    : registered randomized set index
//   lookup_tag_o        : registered tag passthrough
// Configuration macro RANDOM_MODULO_EN (see rm_index_hash): when undefined the
// index is unhashed but the seed register and reseed handshake are unchanged.
// -----------------------------------------------------------------------------
module rm_index_gen
    import rm_index_gen_pkg::*;
#(
    parameter int                    SEED_WIDTH    = RM_SEED_WIDTH,
    parameter int                    RAND_WIDTH    = RM_RAND_WIDTH,
    parameter int                    SET_IDX_WIDTH = RM_SET_IDX_WIDTH,
    parameter int                    OFFSET_WIDTH  = RM_OFFSET_WIDTH,
    parameter int                    ADDR_WIDTH    = RM_ADDR_WIDTH,
    parameter logic [SEED_WIDTH-1:0] RESET_SEED    = '0
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [RAND_WIDTH-1:0]                        rand_i,
    input  logic                                         reseed_req,
    output logic                                         reseed_busy,
    output logic                                         reseed_done,
    input  logic                                         lookup_valid_i,
    input  logic [ADDR_WIDTH-1:0]                        lookup_addr_i,
    output logic                                         lookup_valid_o,
    output logic [SET_IDX_WIDTH-1:0]                     lookup_set_idx_o,
    output logic [ADDR_WIDTH-SET_IDX_WIDTH-OFFSET_WIDTH-1:0] lookup_tag_o
);

    localparam int TAG_WIDTH = ADDR_WIDTH - SET_IDX_WIDTH - OFFSET_WIDTH;

    rm_reseed_state_t          state_q, state_d;
    logic [SEED_WIDTH-1:0]     shadow_q, shadow_d;
    logic [SEED_WIDTH-1:0]     seed_q, seed_d;
    logic                      valid_q, valid_d;
    logic [SET_IDX_WIDTH-1:0]  set_idx_q, set_idx_d;
    logic [TAG_WIDTH-1:0]      tag_q, tag_d;

    logic [SET_IDX_WIDTH-1:0]  addr_idx;
    logic [TAG_WIDTH-1:0]      addr_tag;
    logic [SET_IDX_WIDTH-1:0]  hashed_idx;
    logic                      unused_offset_bits;

    assign addr_idx           = lookup_addr_i[OFFSET_WIDTH +: SET_IDX_WIDTH];
    assign addr_tag           = lookup_addr_i[ADDR_WIDTH-1:OFFSET_WIDTH+SET_IDX_WIDTH];
    assign unused_offset_bits = ^lookup_addr_i[OFFSET_WIDTH-1:0];

    rm_index_hash #(
        .SEED_WIDTH    (SEED_WIDTH),
        .SET_IDX_WIDTH (SET_IDX_WIDTH),
        .TAG_WIDTH     (TAG_WIDTH)
    ) u_hash (
        .tag_i     (addr_tag),
        .idx_i     (addr_idx),
        .seed_i    (seed_q),
        .set_idx_o (hashed_idx)
    );

    // Reseed FSM: two capture cycles fill the shadow, then COMMIT copies it to
    // the live seed at the end of that cycle. Requests outside IDLE are dropped.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        seed_d   = seed_q;
        case (state_q)
            RM_IDLE: begin
                if (reseed_req) begin
                    state_d = RM_CAP_LO;
                end
            end
            RM_CAP_LO: begin
                shadow_d[RAND_WIDTH-1:0] = rand_i;
                state_d                  = RM_CAP_HI;
            end
            RM_CAP_HI: begin
                shadow_d[SEED_WIDTH-1:RAND_WIDTH] = rand_i;
                state_d                           = RM_COMMIT;
            end
            RM_COMMIT: begin
                seed_d  = shadow_q;
                state_d = RM_IDLE;
            end
            default: begin
                state_d = RM_IDLE;
            end
        endcase
    end

    // Lookup stage: valid follows the input every cycle, index/tag hold when
    // no lookup is presented. The seed used is the one registered this cycle.
    always_comb begin
        valid_d   = lookup_valid_i;
        set_idx_d = set_idx_q;
        tag_d     = tag_q;
        if (lookup_valid_i) begin
            set_idx_d = hashed_idx;
            tag_d     = addr_tag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RM_IDLE;
            shadow_q  <= '0;
            seed_q    <= RESET_SEED;
            valid_q   <= 1'b0;
            set_idx_q <= '0;
            tag_q     <= '0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            seed_q    <= seed_d;
            valid_q   <= valid_d;
            set_idx_q <= set_idx_d;
            tag_q     <= tag_d;
        end
    end

    assign reseed_busy      = (state_q != RM_IDLE);
    assign reseed_done      = (state_q == RM_COMMIT);
    assign lookup_valid_o   = valid_q;
    assign lookup_set_idx_o = set_idx_q;
    assign lookup_tag_o     = tag_q;

endmodule

// File: tb/tb_rm_index_gen.sv
// -----------------------------------------------------------------------------
// tb_rm_index_gen
// Scoreboard bench for rm_index_gen. Stimulus pushes the expected lookup
// result into a queue; a negedge monitor pops and compares whenever the DUT
// presents lookup_valid_o. Reseed handshake and reset behaviour are checked
// directly by the stimulus process. Expected indices follow RANDOM_MODULO_EN.
// -----------------------------------------------------------------------------
module tb_rm_index_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] rand_i = '0;
    logic        reseed_req = 1'b0;
    logic        lookup_valid_i = 1'b0;
    logic [31:0] lookup_addr_i = '0;
    logic        reseed_busy;
    logic        reseed_done;
    logic        lookup_valid_o;
    logic [5:0]  lookup_set_idx_o;
    logic [19:0] lookup_tag_o;

    always #5 clk = ~clk;

    rm_index_gen dut (
        .clk              (clk),
        .reset            (reset),
        .rand_i           (rand_i),
        .reseed_req       (reseed_req),
        .reseed_busy      (reseed_busy),
        .reseed_done      (reseed_done),
        .lookup_valid_i   (lookup_valid_i),
        .lookup_addr_i    (lookup_addr_i),
        .lookup_valid_o   (lookup_valid_o),
        .lookup_set_idx_o (lookup_set_idx_o),
        .lookup_tag_o     (lookup_tag_o)
    );

    typedef struct {
        logic [5:0]  set_idx;
        logic [19:0] tag;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          n_compared = 0;
    int          n_mismatched = 0;
    bit          seen [64];
    bit          track_seen = 1'b0;
    logic [31:0] model_seed = 32'h0;

`ifdef RANDOM_MODULO_EN
    localparam logic [5:0] EXP_1040_SEED0 = 6'd3;
`else
    localparam logic [5:0] EXP_1040_SEED0 = 6'd1;
`endif

    // Bit-wise reference: seed bit b folds into k bit (b mod 6); the rotation
    // places idx bit i at position (i + rot) mod 6.
    function automatic logic [5:0] model_idx(input logic [31:0] addr, input logic [31:0] seed);
        logic [5:0]  idx;
        logic [31:0] x;
        logic [5:0]  k;
        logic [5:0]  r;
        int          rot;
        idx = addr[11:6];
        x   = {12'h000, addr[31:12]} ^ seed;
        k   = '0;
        for (int b = 0; b < 32; b++) begin
            k[b % 6] = k[b % 6] ^ x[b];
        end
`ifndef RANDOM_MODULO_EN
        k = '0;
`endif
        rot = int'(k) % 6;
        r   = '0;
        for (int i = 0; i < 6; i++) begin
            r[(i + rot) % 6] = idx[i];
        end
        return r ^ k;
    endfunction

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_compared++;
        if (act !== req) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] addr, input logic [15:0] rnd,
                                 input logic req, input logic [5:0] exp_idx, input string nm);
        @(posedge clk);
        #1;
        lookup_valid_i = valid;
        lookup_addr_i  = addr;
        rand_i         = rnd;
        reseed_req     = req;
        if (valid) begin
            exp_q.push_back('{set_idx: exp_idx, tag: addr[31:12], name: nm});
        end
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    endtask

    // Monitor: pops one expectation per presented lookup result.
    always @(negedge clk) begin
        if (!reset && lookup_valid_o) begin
            if (exp_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL unexpected_valid: got lookup_valid_o=1, required no pending lookup");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput({e.name, "_set_idx"}, 32'(lookup_set_idx_o), 32'(e.set_idx));
                checkOutput({e.name, "_tag"}, 32'(lookup_tag_o), 32'(e.tag));
                if (track_seen) begin
                    seen[lookup_set_idx_o] = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        n_mismatched++;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        summary();
        $finish;
    end

    initial begin
        logic [31:0] addr;
        logic [15:0] rnd;
        logic [31:0] seed_for;
        int          distinct;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset_valid_o", 32'(lookup_valid_o), 32'h0);
        checkOutput("reset_set_idx", 32'(lookup_set_idx_o), 32'h0);
        checkOutput("reset_tag", 32'(lookup_tag_o), 32'h0);
        checkOutput("reset_busy", 32'(reseed_busy), 32'h0);
        checkOutput("reset_done", 32'(reseed_done), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Directed lookups with seed 0
        applyStimulus(1'b1, 32'h0000_0040, 16'h0, 1'b0, 6'd1, "addr_40");
        applyStimulus(1'b1, 32'hFFFF_FFC0, 16'h0, 1'b0, model_idx(32'hFFFF_FFC0, model_seed), "addr_ones");
        applyStimulus(1'b1, 32'h0000_1040, 16'h0, 1'b0, EXP_1040_SEED0, "addr_1040");
        applyStimulus(1'b0, 32'hFFFF_FFFF, 16'h0, 1'b0, 6'd0, "");
        applyStimulus(1'b0, 32'h0000_0000, 16'h0, 1'b0, 6'd0, "");
        #4;
        checkOutput("hold_valid_o", 32'(lookup_valid_o), 32'h0);
        checkOutput("hold_set_idx", 32'(lookup_set_idx_o), 32'(EXP_1040_SEED0));
        checkOutput("hold_tag", 32'(lookup_tag_o), 32'h1);

        // Permutation sweep, tag 5, seed 0
        foreach (seen[j]) seen[j] = 1'b0;
        track_seen = 1'b1;
        for (int i = 0; i < 64; i++) begin
            addr = {20'h00005, 6'(i), 6'h00};
            applyStimulus(1'b1, addr, 16'h0, 1'b0, model_idx(addr, model_seed), $sformatf("perm_t5_i%0d", i));
        end
        applyStimulus(1'b0, 32'h0, 16'h0, 1'b0, 6'd0, "");
        applyStimulus(1'b0, 32'h0, 16'h0, 1'b0, 6'd0, "");
        track_seen = 1'b0;
        distinct = 0;
        foreach (seen[j]) distinct += int'(seen[j]);
        checkOutput("perm_t5_distinct", 32'(distinct), 32'd64);

        // Reseed with lookups every cycle; second request lands in CAP_HI
        for (int s = 0; s < 8; s++) begin
            rnd      = (s == 1) ? 16'hBEEF : (s == 2) ? 16'hDEAD : 16'(16'h5A5A + s);
            seed_for = (s >= 4) ? 32'hDEAD_BEEF : model_seed;
            addr     = {20'(20'h12340 + s), 6'(s * 7), 6'h00};
            applyStimulus(1'b1, addr, rnd, (s == 0) || (s == 2), model_idx(addr, seed_for),
                          $sformatf("reseed_lookup_s%0d", s));
            #4;
            checkOutput($sformatf("reseed_busy_s%0d", s), 32'(reseed_busy), 32'((s >= 1) && (s <= 3)));
            checkOutput($sformatf("reseed_done_s%0d", s), 32'(reseed_done), 32'(s == 3));
        end
        model_seed = 32'hDEAD_BEEF;

        // Permutation sweep, tag 0xABCDE, seed 0xDEADBEEF
        foreach (seen[j]) seen[j] = 1'b0;
        track_seen = 1'b1;
        for (int i = 0; i < 64; i++) begin
            addr = {20'hABCDE, 6'(i), 6'h00};
            applyStimulus(1'b1, addr, 16'h0, 1'b0, model_idx(addr, model_seed), $sformatf("perm_tabcde_i%0d", i));
        end
        applyStimulus(1'b0, 32'h0, 16'h0, 1'b0, 6'd0, "");
        applyStimulus(1'b0, 32'h0, 16'h0, 1'b0, 6'd0, "");
        track_seen = 1'b0;
        distinct = 0;
        foreach (seen[j]) distinct += int'(seen[j]);
        checkOutput("perm_tabcde_distinct", 32'(distinct), 32'd64);

        // Reset asserted while in CAP_HI
        applyStimulus(1'b1, 32'h0000_1040, 16'h7777, 1'b1, model_idx(32'h0000_1040, model_seed), "pre_reset_1040");
        applyStimulus(1'b0, 32'h0, 16'h1111, 1'b0, 6'd0, "");
        #4;
        checkOutput("midrst_busy_caplo", 32'(reseed_busy), 32'h1);
        applyStimulus(1'b0, 32'h0, 16'h2222, 1'b0, 6'd0, "");
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrst_valid_o", 32'(lookup_valid_o), 32'h0);
        checkOutput("midrst_set_idx", 32'(lookup_set_idx_o), 32'h0);
        checkOutput("midrst_tag", 32'(lookup_tag_o), 32'h0);
        checkOutput("midrst_busy", 32'(reseed_busy), 32'h0);
        checkOutput("midrst_done", 32'(reseed_done), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        model_seed = 32'h0;
        for (int s = 0; s < 4; s++) begin
            applyStimulus(1'b0, 32'h0, 16'(16'h3C3C + s), 1'b0, 6'd0, "");
            #4;
            checkOutput($sformatf("postrst_busy_s%0d", s), 32'(reseed_busy), 32'h0);
            checkOutput($sformatf("postrst_done_s%0d", s), 32'(reseed_done), 32'h0);
        end
        applyStimulus(1'b1, 32'h0000_1040, 16'h0, 1'b0, EXP_1040_SEED0, "post_reset_1040");
        applyStimulus(1'b0, 32'h0, 16'h0, 1'b0, 6'd0, "");
        applyStimulus(1'b0, 32'h0, 16'h0, 1'b0, 6'd0, "");
        #4;
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        summary();
        $finish;
    end

endmodule
